// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier datapath: accumulator
// FSM states, saturation bounds for a signed accumulator of a given width,
// and the width of a counter that must reach LEN.
package booth_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Largest value representable by an acc_w-bit signed number.
    function automatic longint sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable by an acc_w-bit signed number.
    function automatic longint sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

    // Bits needed for a counter that runs 0..len inclusive.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating adder: signed ACC_W accumulator plus signed
// PROD_W addend, evaluated at ACC_W+1 bits and clamped back to ACC_W.
module sat_adder
    import booth_pkg::*;
#(
    parameter int ACC_W  = 12,
    parameter int PROD_W = 8
) (
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic signed [PROD_W-1:0] addend,
    output logic signed [ACC_W-1:0]  sum_out,
    output logic                     sat_hit
);

    localparam int EXT_W = ACC_W + 1 - PROD_W;
    localparam logic signed [ACC_W-1:0] MAX_C = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN_C = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] wide_s;

    // Widen both operands by sign extension, add, and clamp when the top two bits disagree.
    always_comb begin
        wide_s = {acc_in[ACC_W-1], acc_in} + {{EXT_W{addend[PROD_W-1]}}, addend};
        if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
            sat_hit = 1'b1;
            sum_out = wide_s[ACC_W] ? MIN_C : MAX_C;
        end else begin
            sat_hit = 1'b0;
            sum_out = wide_s[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates LEN signed products from the Booth multiplier into one
// saturated dot-product result and presents it on a valid/ready port.
// While a result is held, no new products are accepted.
module product_accumulator
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN   = 4,
    parameter int ACC_W = 12,
    localparam int PROD_W = 2 * WIDTH,
    localparam int CNT_W  = cnt_w(LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         count
);

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("product_accumulator: ACC_W must be >= 2*WIDTH");
    end
    if (LEN < 2) begin : g_bad_len
        $error("product_accumulator: LEN must be >= 2");
    end

    localparam logic [CNT_W-1:0]        LAST_C   = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0]        ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CZERO_C  = CNT_W'(0);
    localparam logic signed [ACC_W-1:0] AZERO_C  = ACC_W'(0);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;

    logic signed [ACC_W-1:0] sum_s;
    logic                    sat_s;

    sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_adder (
        .acc_in  (acc_q),
        .addend  (in_product),
        .sum_out (sum_s),
        .sat_hit (sat_s)
    );

    // Next-state logic: clear flushes everything except the last out_sum; ACCUM folds in products; HOLD waits for the consumer.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        if (clear) begin
            state_d     = ACCUM;
            acc_d       = AZERO_C;
            ovf_d       = 1'b0;
            count_d     = CZERO_C;
            out_ovf_d   = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid && in_ready_q) begin
                        acc_d   = sum_s;
                        ovf_d   = ovf_q | sat_s;
                        count_d = count_q + ONE_C;
                        if (count_q == LAST_C) begin
                            out_sum_d   = sum_s;
                            out_ovf_d   = ovf_q | sat_s;
                            out_valid_d = 1'b1;
                            in_ready_d  = 1'b0;
                            state_d     = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d     = ACCUM;
                        acc_d       = AZERO_C;
                        ovf_d       = 1'b0;
                        count_d     = CZERO_C;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d     = ACCUM;
                    acc_d       = AZERO_C;
                    ovf_d       = 1'b0;
                    count_d     = CZERO_C;
                    out_ovf_d   = 1'b0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCUM;
            acc_q       <= AZERO_C;
            ovf_q       <= 1'b0;
            count_q     <= CZERO_C;
            out_sum_q   <= AZERO_C;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 12-bit and an 8-bit accumulator share
// one input stream; every result is compared against a saturating
// dot-product model applied to the list of accepted products.
module tb_product_accumulator;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic signed [7:0] in_product = 8'sd0;

    logic              in_ready, out_valid, out_ovf;
    logic signed [11:0] out_sum;
    logic [2:0]        count;
    logic              in_ready8, out_valid8, out_ovf8;
    logic signed [7:0] out_sum8;
    logic [2:0]        count8;

    int n_cmp = 0;
    int n_mis = 0;
    int cur_q[$];

    always #5 clk = ~clk;

    product_accumulator #(.WIDTH(4), .LEN(4), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf), .count(count)
    );

    product_accumulator #(.WIDTH(4), .LEN(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
        .in_product(in_product), .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_ovf(out_ovf8), .count(count8)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Saturating sum of a list of products in an acc_w-bit signed accumulator.
    function automatic void ref_model(input int prods[$], input int acc_w,
                                      output longint sum, output bit ovf);
        longint hi, lo;
        hi = (longint'(1) <<< (acc_w - 1)) - 1;
        lo = -(longint'(1) <<< (acc_w - 1));
        sum = 0;
        ovf = 1'b0;
        foreach (prods[i]) begin
            sum = sum + prods[i];
            if (sum > hi) begin
                sum = hi;
                ovf = 1'b1;
            end else if (sum < lo) begin
                sum = lo;
                ovf = 1'b1;
            end
        end
    endfunction

    // Present one product and hold it until it is accepted.
    task automatic send(input int p);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_product = 8'(p);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 0, 1);
        end else begin
            @(posedge clk); #1;
            cur_q.push_back(p);
        end
        in_valid = 1'b0;
    endtask

    // Wait for a result, check both accumulators against the model, then consume it.
    task automatic get_result(input int delay, output longint s12, output longint s8,
                              output bit o8);
        int n;
        longint e12, e8;
        bit eo12, eo8;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("res_valid", out_valid, 1);
        check_eq("res_valid8", out_valid8, 1);
        ref_model(cur_q, 12, e12, eo12);
        ref_model(cur_q, 8, e8, eo8);
        check_eq("res_sum12", out_sum, e12);
        check_eq("res_ovf12", out_ovf, eo12);
        check_eq("res_sum8", out_sum8, e8);
        check_eq("res_ovf8", out_ovf8, eo8);
        check_eq("res_count", count, 4);
        check_eq("res_in_ready", in_ready, 0);
        s12 = out_sum;
        s8 = out_sum8;
        o8 = out_ovf8;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check_eq("res_hold_sum", out_sum, e12);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("res_consumed", out_valid, 0);
        check_eq("res_cnt_zero", count, 0);
        cur_q.delete();
    endtask

    initial begin
        longint s12, s8;
        bit o8;
        int p;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_sum", out_sum, 0);
        check_eq("rst_out_ovf", out_ovf, 0);
        check_eq("rst_count", count, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: back-to-back with out_ready held high
        out_ready = 1'b1;
        send(12); send(-12); send(-12);
        check_eq("t1_count3", count, 3);
        send(12);
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_sum", out_sum, 0);
        check_eq("t1_ovf", out_ovf, 0);
        check_eq("t1_count", count, 4);
        @(posedge clk); #1;
        check_eq("t1_one_cycle", out_valid, 0);
        check_eq("t1_ready_back", in_ready, 1);
        out_ready = 1'b0;
        cur_q.delete();

        // 2: saturation and recovery (8-bit accumulator clamps)
        send(64); send(64); send(-8); send(1);
        get_result(0, s12, s8, o8);
        check_eq("t2_sum8", s8, 120);
        check_eq("t2_ovf8", o8, 1);
        check_eq("t2_sum12", s12, 121);

        // 3: backpressure with in_valid pulses during HOLD
        send(7); send(14); send(-6); send(1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_product = 8'(int'($urandom_range(0, 255)) - 128);
            @(posedge clk); #1;
            check_eq("t3_valid", out_valid, 1);
            check_eq("t3_in_ready", in_ready, 0);
            check_eq("t3_sum", out_sum, 16);
            check_eq("t3_count", count, 4);
        end
        in_valid = 1'b0;
        get_result(0, s12, s8, o8);
        check_eq("t3_res", s12, 16);

        // 4: clear discards partial sum and a simultaneous product
        send(5); send(5);
        clear = 1'b1;
        in_valid = 1'b1;
        in_product = 8'sd9;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check_eq("t4_count", count, 0);
        check_eq("t4_valid", out_valid, 0);
        cur_q.delete();
        send(1); send(1); send(1); send(1);
        get_result(1, s12, s8, o8);
        check_eq("t4_res", s12, 4);

        // 5: asynchronous reset mid-accumulation
        send(3); send(3); send(3);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_count", count, 0);
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_out_sum", out_sum, 0);
        check_eq("t5_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        cur_q.delete();
        send(2); send(2); send(2); send(2);
        get_result(0, s12, s8, o8);
        check_eq("t5_res", s12, 8);

        // 6: random sparse traffic over 20 results
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 4; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #0;
                p = int'($urandom_range(0, 255)) - 128;
                send(p);
            end
            get_result(int'($urandom_range(0, 2)), s12, s8, o8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
